l1_miss_ctrl: RTL

L1_MISS_CTRL -- requirements
Module: l1_miss_ctrl
Interface
REQ-001 SHALL have parameter RSP_TIMEOUT, default 255, the maximum number of WAIT_RSP cycles before abort.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port miss_valid  input  1  the cache miss request.
REQ-005 SHALL have port miss_ready  output  1  the miss is accepted.
REQ-006 SHALL have port miss_addr  input  48  the miss byte address.
REQ-007 SHALL have port miss_unique  input  1  the miss needs ownership (write miss).
REQ-008 SHALL have port req_valid  output  1  the interconnect request is valid.
REQ-009 SHALL have port req_ready  input  1  the interconnect accepts the request.
REQ-010 SHALL have port req_opcode  output  2  the request opcode (req_opcode_e).
REQ-011 SHALL have port req_addr  output  48  the line-aligned request address.
REQ-012 SHALL have port req_data  output  512  the writeback data, zero for reads.
REQ-013 SHALL have port rsp_valid  input  1  the read response is valid.
REQ-014 SHALL have port rsp_ready  output  1  the response is accepted.
REQ-015 SHALL have port rsp_data  input  512  the response line data.
REQ-016 SHALL have port rsp_state  input  4  the granted MESI state.
REQ-017 SHALL have port fill_valid  output  1  the fill to the cache is valid.
REQ-018 SHALL have port fill_ready  input  1  the cache accepts the fill.
REQ-019 SHALL have port fill_addr  output  48  the line-aligned fill address.
REQ-020 SHALL have port fill_data  output  512  the fill line data.
REQ-021 SHALL have port fill_state  output  4  the fill MESI state.
REQ-022 SHALL have port evict_valid  input  1  the cache presents a victim.
REQ-023 SHALL have port evict_ready  output  1  the victim is consumed.
REQ-024 SHALL have port evict_addr  input  48  the victim line address.
REQ-025 SHALL have port evict_data  input  512  the victim data.
REQ-026 SHALL have port evict_dirty  input  1  the victim is dirty.
REQ-027 SHALL have port err  output  1  sticky error flag for timeout or INVALID grant.
Function
REQ-028 SHALL implement FSM states IDLE, REQ, WAIT_RSP, FILL, EVICT_CHK, WB, with one miss outstanding at a time.
REQ-029 In IDLE, miss_ready SHALL be 1; on miss_valid it SHALL latch {miss_addr[47:6],6'b0} and miss_unique, then go to REQ.
REQ-030 In REQ, req_valid SHALL be 1 with opcode READ_UNIQUE if the miss is unique, otherwise READ_SHARED; on req_ready the FSM SHALL go to WAIT_RSP (earliest req_valid is the cycle after the miss is accepted).
REQ-031 req_valid/fill_valid SHALL stay high, with stable addr/data/opcode/state, until the matching ready is seen; they SHALL never drop without a handshake.
REQ-032 In WAIT_RSP, rsp_ready SHALL be 1; on rsp_valid it SHALL capture rsp_data and rsp_state and go to FILL, so fill_valid rises the next cycle.
REQ-033 If rsp_state==INVALID, or the WAIT_RSP cycle counter reaches RSP_TIMEOUT without rsp_valid, err SHALL set and the FSM SHALL return to IDLE with no fill issued.
REQ-034 A unique miss granted SHARED SHALL set err but still fill with SHARED.
REQ-035 The counter SHALL clear on entering WAIT_RSP and saturate, never wrap; if rsp_valid arrives in the same cycle as the timeout, the response SHALL win.
REQ-036 After the fill handshake the FSM SHALL enter EVICT_CHK for exactly one cycle; evict_ready SHALL equal evict_valid there and be 0 in all other states.
REQ-037 In EVICT_CHK: evict_valid&&evict_dirty SHALL latch evict_addr/evict_data and go to WB; any other case SHALL go to IDLE (a clean victim is dropped).
REQ-038 In WB, req_valid SHALL be 1 with opcode WRITE_BACK, the latched victim address and data; on req_ready the FSM SHALL go to IDLE.
REQ-039 err SHALL clear only on reset.
Reset
REQ-040 On reset: FSM SHALL be IDLE, all outputs 0 except miss_ready=1, latched registers and counter 0, err 0; reset mid-transaction SHALL abandon it silently.
Structure
REQ-041 req_opcode_e (READ_SHARED=0, READ_UNIQUE=1, WRITE_BACK=2) and the MESI encodings (I=0, S=1, E=2, M=3) SHALL live in coh_noc_pkg.
REQ-042 The block SHALL be a single module with no sub-modules.
Verification
REQ-043 Miss addr 0x1234_5678_9ABF, unique=0, req_ready=1, rsp_state=E -> req READ_SHARED addr 0x1234_5678_9A80, then fill_state=E at the same address.
REQ-044 Unique miss, fill accepted, evict_valid=1 with dirty=1 and addr 0x4000 -> WRITE_BACK req to 0x4000 carrying evict_data.
REQ-045 Same as REQ-044 with dirty=0 -> one-cycle evict_ready pulse, no WB request, return to IDLE.
REQ-046 RSP_TIMEOUT=4, no response -> err=1 after 4 WAIT_RSP cycles, no fill, miss_ready=1 again.
REQ-047 fill_ready held low 5 cycles -> fill_valid/addr/data stable throughout; rst_n asserted during WAIT_RSP -> outputs return to reset values immediately.

---
 rtl/coh_noc_pkg.sv | 19 +
 rtl/l1_miss_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/coh_noc_pkg.sv
// Shared coherence-NoC encodings: request opcodes and MESI line states.
package coh_noc_pkg;

  typedef enum logic [1:0] {
    READ_SHARED = 2'd0,
    READ_UNIQUE = 2'd1,
    WRITE_BACK  = 2'd2
  } req_opcode_e;

  typedef enum logic [3:0] {
    MESI_I = 4'd0,
    MESI_S = 4'd1,
    MESI_E = 4'd2,
    MESI_M = 4'd3
  } mesi_e;

  localparam int unsigned LINE_OFF = 6;

endpackage

// File: rtl/l1_miss_ctrl.sv
// L1 miss controller: one outstanding miss, read request, fill, optional dirty-victim writeback.
module l1_miss_ctrl
  import coh_noc_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_valid,
  output logic         miss_ready,
  input  logic [47:0]  miss_addr,
  input  logic         miss_unique,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [1:0]   req_opcode,
  output logic [47:0]  req_addr,
  output logic [511:0] req_data,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic [511:0] rsp_data,
  input  logic [3:0]   rsp_state,
  output logic         fill_valid,
  input  logic         fill_ready,
  output logic [47:0]  fill_addr,
  output logic [511:0] fill_data,
  output logic [3:0]   fill_state,
  input  logic         evict_valid,
  output logic         evict_ready,
  input  logic [47:0]  evict_addr,
  input  logic [511:0] evict_data,
  input  logic         evict_dirty,
  output logic         err
);

  localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_FILL,
    ST_EVICT_CHK,
    ST_WB
  } state_e;

  state_e             r_st;
  state_e             w_st_nxt;
  logic [47:0]        r_addr;
  logic [511:0]       r_data;
  logic [3:0]         r_mesi;
  logic               r_unique;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_timeout;
  logic               w_wb_take;

  assign w_timeout = (r_cnt == CNT_LAST);
  assign w_wb_take = evict_valid && evict_dirty;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt    = r_st;
    miss_ready  = 1'b0;
    req_valid   = 1'b0;
    req_opcode  = READ_SHARED;
    req_addr    = '0;
    req_data    = '0;
    rsp_ready   = 1'b0;
    fill_valid  = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    fill_state  = '0;
    evict_ready = 1'b0;
    case (r_st)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) w_st_nxt = ST_REQ;
      end
      ST_REQ: begin
        req_valid  = 1'b1;
        req_opcode = r_unique ? READ_UNIQUE : READ_SHARED;
        req_addr   = r_addr;
        if (req_ready) w_st_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        rsp_ready = 1'b1;
        // A response in the timeout cycle still wins.
        if (rsp_valid)      w_st_nxt = (rsp_state == MESI_I) ? ST_IDLE : ST_FILL;
        else if (w_timeout) w_st_nxt = ST_IDLE;
      end
      ST_FILL: begin
        fill_valid = 1'b1;
        fill_addr  = r_addr;
        fill_data  = r_data;
        fill_state = r_mesi;
        if (fill_ready) w_st_nxt = ST_EVICT_CHK;
      end
      ST_EVICT_CHK: begin
        evict_ready = evict_valid;
        w_st_nxt    = w_wb_take ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        req_valid  = 1'b1;
        req_opcode = WRITE_BACK;
        req_addr   = r_addr;
        req_data   = r_data;
        if (req_ready) w_st_nxt = ST_IDLE;
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // The line address/data buffers are reused for the victim once the fill has been handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_mesi   <= '0;
      r_unique <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (miss_valid) begin
            r_addr   <= {miss_addr[47:LINE_OFF], {LINE_OFF{1'b0}}};
            r_unique <= miss_unique;
          end
        end
        ST_REQ: begin
          if (req_ready) r_cnt <= '0;
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            r_data <= rsp_data;
            r_mesi <= rsp_state;
            if ((rsp_state == MESI_I) || (r_unique && (rsp_state == MESI_S)))
              r_err <= 1'b1;
          end else begin
            if (w_timeout) r_err <= 1'b1;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_EVICT_CHK: begin
          if (w_wb_take) begin
            r_addr <= {evict_addr[47:LINE_OFF], {LINE_OFF{1'b0}}};
            r_data <= evict_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
